line_animator_multi: RTL and testbench

- Parametrised successor to the single-line animator; owns its own Bresenham engine instead of instantiating line_drawer, so coordinate width is generic.
- Draws a line segment of fixed extent and erases it (same pixels, colour 0) on each update event. It then translates the line by a step vector.
- Runs in wrap or bounce mode over a configurable number of positions, with update events latched so none are lost mid-draw.
- Sits between the frame-tick source and the framebuffer write port.

---
 rtl/line_animator_multi.sv | 223 ++++++++++++++++++++++
 tb/tb_line_animator_multi.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_animator_multi.sv
// Purpose : animates a fixed-extent line. Each update event erases the line, steps its position and redraws it.
// Latency : first erase pixel 2 cycles after an event seen in HOLD; one pixel per cycle while drawing or erasing.
// Backpress: none. Pixels are emitted unconditionally. Events that arrive while busy collapse into one pending request.
//
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   update_event        request for the next animation step (any pulse width)
//   bounce_mode         0 = wrap, 1 = ping-pong; sampled when the step advances
//   x, y                pixel coordinate (hold their value while pixel_valid is low)
//   pixel_color         1 = draw (white), 0 = erase (black); low whenever pixel_valid is low
//   pixel_valid         x/y/pixel_color form a framebuffer write this cycle
//   frame_done          pulses on the last drawn pixel of a line
//   step                current animation position
module line_animator_multi #(
    parameter int COORD_W = 11,
    parameter int STEPS   = 128,
    parameter int DX_LEN  = 10,
    parameter int DY_LEN  = 15,
    parameter int STEP_DX = 1,
    parameter int STEP_DY = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     update_event,
    input  logic                     bounce_mode,
    output logic [COORD_W-1:0]       x,
    output logic [COORD_W-1:0]       y,
    output logic                     pixel_color,
    output logic                     pixel_valid,
    output logic                     frame_done,
    output logic [$clog2(STEPS)-1:0] step
);

    localparam int SW    = $clog2(STEPS);
    // The error term needs two bits beyond the coordinate width to hold +/- extents.
    // The doubled error term (e2) needs one more bit on top of that.
    localparam int EW    = COORD_W + 2;
    localparam int N_PIX = ((DX_LEN > DY_LEN) ? DX_LEN : DY_LEN) + 1;

    localparam logic [COORD_W-1:0]   LAST_IDX  = COORD_W'(N_PIX - 1);
    localparam logic [COORD_W-1:0]   CNT_ONE   = COORD_W'(1);
    localparam logic [COORD_W-1:0]   SDX       = COORD_W'(STEP_DX);
    localparam logic [COORD_W-1:0]   SDY       = COORD_W'(STEP_DY);
    localparam logic signed [EW:0]   DX_E      = (EW + 1)'(DX_LEN);
    localparam logic signed [EW:0]   DY_E      = (EW + 1)'(DY_LEN);
    localparam logic signed [EW-1:0] ERR0      = EW'(DX_LEN - DY_LEN);
    localparam logic [SW-1:0]        STEP_MAX  = SW'(STEPS - 1);
    localparam logic [SW-1:0]        STEP_ONE  = SW'(1);

    // Every endpoint reached by the animation must fit in COORD_W bits.
    localparam longint X_SPAN = longint'(STEPS - 1) * longint'(STEP_DX) + longint'(DX_LEN);
    localparam longint Y_SPAN = longint'(STEPS - 1) * longint'(STEP_DY) + longint'(DY_LEN);
    localparam longint C_LIM  = longint'(1) << COORD_W;

    if (STEPS < 2) begin : g_bad_steps
        $error("line_animator_multi: STEPS must be at least 2");
    end
    if (DX_LEN < 0 || DY_LEN < 0) begin : g_bad_len
        $error("line_animator_multi: DX_LEN and DY_LEN must be non-negative");
    end
    if (X_SPAN >= C_LIM) begin : g_bad_xspan
        $error("line_animator_multi: x range exceeds COORD_W");
    end
    if (Y_SPAN >= C_LIM) begin : g_bad_yspan
        $error("line_animator_multi: y range exceeds COORD_W");
    end

    typedef enum logic [2:0] {
        LOAD_D  = 3'd0,
        DRAW    = 3'd1,
        HOLD    = 3'd2,
        LOAD_E  = 3'd3,
        ERASE   = 3'd4,
        ADVANCE = 3'd5
    } state_t;

    state_t                 state;
    state_t                 state_nx;
    logic [COORD_W-1:0]     pix_cnt;
    logic signed [EW-1:0]   err;
    logic signed [EW:0]     err_w;
    logic signed [EW:0]     e2;
    logic signed [EW:0]     err_nx_w;
    logic                   x_inc;
    logic                   y_inc;
    logic                   last_pix;
    logic                   dir_up;
    logic                   pending;
    logic [COORD_W-1:0]     x0;
    logic [COORD_W-1:0]     y0;

    // Start point of the line at the current animation position.
    assign x0       = COORD_W'(step) * SDX;
    assign y0       = COORD_W'(step) * SDY;
    assign last_pix = (pix_cnt == LAST_IDX);

    // One Bresenham step. Both decisions use the same e2.
    always_comb begin
        err_w    = {err[EW-1], err};
        e2       = err_w <<< 1;
        x_inc    = (e2 > -DY_E);
        y_inc    = (e2 < DX_E);
        err_nx_w = err_w;
        if (x_inc) begin
            err_nx_w = err_nx_w - DY_E;
        end
        if (y_inc) begin
            err_nx_w = err_nx_w + DX_E;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= LOAD_D;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and pixel strobes. pixel_valid, pixel_color and frame_done
    // are decoded from the state, so reset forces them low immediately.
    always_comb begin
        state_nx    = state;
        pixel_valid = 1'b0;
        pixel_color = 1'b0;
        frame_done  = 1'b0;
        unique case (state)
            LOAD_D: begin
                state_nx = DRAW;
            end
            DRAW: begin
                pixel_valid = 1'b1;
                pixel_color = 1'b1;
                if (last_pix) begin
                    frame_done = 1'b1;
                    state_nx   = HOLD;
                end
            end
            HOLD: begin
                if (pending || update_event) begin
                    state_nx = LOAD_E;
                end
            end
            LOAD_E: begin
                state_nx = ERASE;
            end
            ERASE: begin
                pixel_valid = 1'b1;
                if (last_pix) begin
                    state_nx = ADVANCE;
                end
            end
            ADVANCE: begin
                state_nx = LOAD_D;
            end
            default: begin
                state_nx = LOAD_D;
            end
        endcase
    end

    // Engine, position and pending-event state.
    // x/y are loaded during LOAD_D/LOAD_E. They therefore change only on the
    // edge that enters DRAW/ERASE and hold during every non-pixel cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x       <= '0;
            y       <= '0;
            err     <= '0;
            pix_cnt <= '0;
            step    <= '0;
            dir_up  <= 1'b1;
            pending <= 1'b0;
        end else begin
            // An event in the LOAD_E cycle re-arms pending rather than being lost.
            if (state == LOAD_E) begin
                pending <= update_event;
            end else if (state != HOLD && update_event) begin
                pending <= 1'b1;
            end

            unique case (state)
                LOAD_D, LOAD_E: begin
                    x       <= x0;
                    y       <= y0;
                    err     <= ERR0;
                    pix_cnt <= '0;
                end
                DRAW, ERASE: begin
                    if (!last_pix) begin
                        x       <= x + COORD_W'(x_inc);
                        y       <= y + COORD_W'(y_inc);
                        err     <= err_nx_w[EW-1:0];
                        pix_cnt <= pix_cnt + CNT_ONE;
                    end
                end
                ADVANCE: begin
                    if (!bounce_mode) begin
                        dir_up <= 1'b1;
                        step   <= (step == STEP_MAX) ? '0 : step + STEP_ONE;
                    end else if (dir_up) begin
                        if (step == STEP_MAX) begin
                            dir_up <= 1'b0;
                            step   <= STEP_MAX - STEP_ONE;
                        end else begin
                            step <= step + STEP_ONE;
                        end
                    end else begin
                        if (step == '0) begin
                            dir_up <= 1'b1;
                            step   <= STEP_ONE;
                        end else begin
                            step <= step - STEP_ONE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_animator_multi.sv
module tb_line_animator_multi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic ev;
    logic bmode;
    logic sel;

    logic a_reset, b_reset, a_ev, b_ev;
    assign a_reset = sel ? 1'b1 : rst;
    assign b_reset = sel ? rst : 1'b1;
    assign a_ev    = sel ? 1'b0 : ev;
    assign b_ev    = sel ? ev : 1'b0;

    logic [10:0] a_x, a_y;
    logic        a_col, a_vld, a_fd;
    logic [6:0]  a_step;
    logic [7:0]  b_x, b_y;
    logic        b_col, b_vld, b_fd;
    logic [1:0]  b_step;

    line_animator_multi dut_a (
        .clk(clk), .reset(a_reset), .update_event(a_ev), .bounce_mode(bmode),
        .x(a_x), .y(a_y), .pixel_color(a_col), .pixel_valid(a_vld),
        .frame_done(a_fd), .step(a_step)
    );

    line_animator_multi #(
        .COORD_W(8), .STEPS(4), .DX_LEN(5), .DY_LEN(2), .STEP_DX(3), .STEP_DY(0)
    ) dut_b (
        .clk(clk), .reset(b_reset), .update_event(b_ev), .bounce_mode(bmode),
        .x(b_x), .y(b_y), .pixel_color(b_col), .pixel_valid(b_vld),
        .frame_done(b_fd), .step(b_step)
    );

    logic [10:0] m_x, m_y;
    logic        m_col, m_vld, m_fd;
    logic [6:0]  m_step;
    always_comb begin
        if (sel) begin
            m_x = {3'b000, b_x}; m_y = {3'b000, b_y};
            m_col = b_col; m_vld = b_vld; m_fd = b_fd; m_step = {5'b0, b_step};
        end else begin
            m_x = a_x; m_y = a_y;
            m_col = a_col; m_vld = a_vld; m_fd = a_fd; m_step = a_step;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: parameters of the selected DUT and its expected state.
    int p_steps, p_dx, p_dy, p_sdx, p_sdy, p_n;
    int mstep;
    bit mdir_up;
    bit pend;
    int ex[$];
    int ey[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_cfg(input int steps, input int dxl, input int dyl, input int sdx, input int sdy);
        p_steps = steps; p_dx = dxl; p_dy = dyl; p_sdx = sdx; p_sdy = sdy;
        p_n = ((dxl > dyl) ? dxl : dyl) + 1;
    endtask

    // Expected pixel list for the line at the current model position.
    task automatic build_line();
        int x0, y0, x1, y1, dx, dy, err, e2, cx, cy;
        x0 = mstep * p_sdx; y0 = mstep * p_sdy;
        x1 = x0 + p_dx;     y1 = y0 + p_dy;
        dx = x1 - x0; dy = y1 - y0; err = dx - dy;
        cx = x0; cy = y0;
        ex.delete(); ey.delete();
        for (int i = 0; i < p_n; i++) begin
            ex.push_back(cx); ey.push_back(cy);
            e2 = 2 * err;
            if (e2 > -dy) begin err -= dy; cx++; end
            if (e2 < dx)  begin err += dx; cy++; end
        end
    endtask

    task automatic model_advance();
        if (!bmode) begin
            mdir_up = 1'b1;
            mstep = (mstep + 1) % p_steps;
        end else if (mdir_up) begin
            if (mstep == p_steps - 1) begin mdir_up = 1'b0; mstep = p_steps - 2; end
            else mstep = mstep + 1;
        end else begin
            if (mstep == 0) begin mdir_up = 1'b1; mstep = 1; end
            else mstep = mstep - 1;
        end
    endtask

    function automatic logic [31:0] rmask();
        if ($urandom_range(0, 3) == 0) return 32'($urandom_range(1, 63));
        return 32'd0;
    endfunction

    // Wait for a pixel burst, then check every pixel. mask[i] drives update_event during pixel i.
    task automatic capture(input bit col, input int exp_off, input logic [31:0] mask);
        int off = 0;
        int i = 0;
        do begin
            @(negedge clk);
            off++;
        end while (!m_vld && off < 40);
        if (!m_vld) begin
            check_val("burst_start_timeout", 32'(m_vld), 32'd1);
            return;
        end
        if (exp_off >= 0) check_val("burst_latency", off, exp_off);
        while (m_vld && i < 40) begin
            ev = (i < 32) ? mask[i] : 1'b0;
            check_val("color", m_col, col);
            check_val("frame_done", m_fd, (col && i == p_n - 1));
            check_val("step_during_burst", m_step, mstep);
            if (i < p_n) begin
                check_val("px_x", m_x, ex[i]);
                check_val("px_y", m_y, ey[i]);
            end
            if (i == 0) begin
                check_val("first_x", m_x, mstep * p_sdx);
                check_val("first_y", m_y, mstep * p_sdy);
            end
            if (i == p_n - 1) begin
                check_val("last_x", m_x, mstep * p_sdx + p_dx);
                check_val("last_y", m_y, mstep * p_sdy + p_dy);
            end
            i++;
            @(negedge clk);
        end
        ev = 1'b0;
        check_val("pixel_count", i, p_n);
    endtask

    task automatic hold_check(input int cycles);
        repeat (cycles) begin
            @(negedge clk);
            check_val("hold_valid", m_vld, 0);
            check_val("hold_color", m_col, 0);
            check_val("hold_fdone", m_fd, 0);
            check_val("hold_x", m_x, ex[p_n - 1]);
            check_val("hold_y", m_y, ey[p_n - 1]);
        end
    endtask

    task automatic run_update(input bit mode, input logic [31:0] emask, input logic [31:0] dmask);
        bmode = mode;
        if (!pend) begin
            hold_check($urandom_range(1, 3));
            ev = 1'b1;
            @(negedge clk);
            ev = 1'b0;
            check_val("load_e_valid", m_vld, 0);
            capture(1'b0, 1, emask);
        end else begin
            capture(1'b0, 2, emask);
        end
        model_advance();
        build_line();
        capture(1'b1, 2, dmask);
        pend = (emask != 0) || (dmask != 0);
    endtask

    task automatic model_reset();
        mstep = 0; mdir_up = 1'b1; pend = 1'b0;
        build_line();
    endtask

    task automatic do_reset();
        rst = 1'b1; ev = 1'b0;
        @(negedge clk);
        check_val("rst_valid", m_vld, 0);
        check_val("rst_color", m_col, 0);
        check_val("rst_fdone", m_fd, 0);
        check_val("rst_x", m_x, 0);
        check_val("rst_y", m_y, 0);
        check_val("rst_step", m_step, 0);
        rst = 1'b0;
        model_reset();
        capture(1'b1, 1, 32'd0);
        hold_check(3);
    endtask

    // Reset asserted between clock edges part-way through an erase.
    task automatic reset_mid_erase();
        hold_check(1);
        ev = 1'b1;
        @(negedge clk);
        ev = 1'b0;
        @(negedge clk);
        check_val("mid_erase_started", m_vld, 1);
        repeat (3) @(negedge clk);
        check_val("mid_erase_valid", m_vld, 1);
        check_val("mid_erase_color", m_col, 0);
        #2 rst = 1'b1;
        #1;
        check_val("async_valid", m_vld, 0);
        check_val("async_color", m_col, 0);
        check_val("async_fdone", m_fd, 0);
        check_val("async_x", m_x, 0);
        check_val("async_y", m_y, 0);
        check_val("async_step", m_step, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        capture(1'b1, 1, 32'd0);
        hold_check(2);
    endtask

    initial begin
        sel = 1'b0; rst = 1'b1; ev = 1'b0; bmode = 1'b0;
        set_cfg(128, 10, 15, 1, 1);
        model_reset();

        do_reset();
        run_update(1'b0, 32'd0, 32'd0);
        check_val("first_update_step", m_step, 1);
        // Three separate pulses during a draw collapse into one automatic update.
        run_update(1'b0, 32'd0, 32'b10101);
        run_update(1'b0, 32'd0, 32'd0);
        check_val("latched_step", m_step, 3);
        hold_check(4);

        for (int k = 0; k < 200 && mstep != 127; k++) run_update(1'b0, rmask(), rmask());
        check_val("wrap_top_step", m_step, 127);
        run_update(1'b0, rmask(), rmask());
        check_val("wrap_to_zero", m_step, 0);

        for (int k = 0; k < 200 && mstep != 127; k++) run_update(1'b0, rmask(), rmask());
        run_update(1'b1, rmask(), rmask());
        check_val("bounce_top", m_step, 126);
        run_update(1'b1, rmask(), rmask());
        run_update(1'b0, rmask(), rmask());
        check_val("wrap_while_descending", m_step, 126);
        for (int k = 0; k < 300 && !(mstep == 0 && !mdir_up); k++) run_update(1'b1, rmask(), rmask());
        check_val("bounce_reach_zero", m_step, 0);
        run_update(1'b1, rmask(), rmask());
        check_val("bounce_bottom", m_step, 1);
        run_update(1'b1, 32'd0, 32'd0);
        reset_mid_erase();

        for (int k = 0; k < 20; k++) run_update(1'($urandom_range(0, 1)), rmask(), rmask());

        // Second configuration: 6 pixels per line, y range 0..2, wrap after step 3.
        rst = 1'b1;
        sel = 1'b1;
        set_cfg(4, 5, 2, 3, 0);
        do_reset();
        for (int k = 0; k < 10 && mstep != 3; k++) run_update(1'b0, rmask(), rmask());
        check_val("b_wrap_top", m_step, 3);
        run_update(1'b0, rmask(), rmask());
        check_val("b_wrap_zero", m_step, 0);
        for (int k = 0; k < 12; k++) run_update(1'($urandom_range(0, 1)), rmask(), rmask());
        run_update(1'b0, 32'd0, 32'd0);
        reset_mid_erase();
        for (int k = 0; k < 8; k++) run_update(1'($urandom_range(0, 1)), rmask(), rmask());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
